// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ requesters.
// Only one registered write is in flight; rejected writes are retried up to MAX_RETRY times.
module fifo_wr_arbiter #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            drop,
   output logic                          fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_full,
   input  logic                          fifo_almostfull,
   output logic                          busy,
   output logic [15:0]                   drop_count
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
   localparam logic [RW-1:0] LAST_TRY = RW'(MAX_RETRY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           ptr_q, ptr_d, sel_q, sel_d;
   logic [PW-1:0]           pick, cand, sel_inc;
   logic [PW:0]             sum;
   logic                    found;
   logic [RW-1:0]           retry_q, retry_d;
   logic                    wr_en_d;
   logic [FIFO_WIDTH-1:0]   data_d;
   logic [NUM_REQ-1:0]      gnt_d, drop_d;
   logic [15:0]             dcnt_d;
   logic [FIFO_WIDTH-1:0]   data_arr [NUM_REQ];
   logic                    unused_almostfull;

   // With a single write in flight the full flag alone is sufficient.
   assign unused_almostfull = fifo_almostfull;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
      assign data_arr[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
   end

   // First active request at or after ptr, wrapping past NUM_REQ-1.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      sum   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
         cand = sum[PW-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign sel_inc = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      retry_d = retry_q;
      wr_en_d = 1'b0;
      data_d  = fifo_data_in;
      gnt_d   = '0;
      drop_d  = '0;
      dcnt_d  = drop_count;
      unique case (state_q)
         IDLE: begin
            if (found && !fifo_full) begin
               sel_d   = pick;
               wr_en_d = 1'b1;
               data_d  = data_arr[pick];
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = ACK;
         ACK: begin
            state_d = IDLE;
            if (fifo_wr_ack) begin
               gnt_d[sel_q] = 1'b1;
               ptr_d        = sel_inc;
               retry_d      = '0;
            end else if (retry_q != LAST_TRY) begin
               // Pointer stays on the rejected requester so it wins the next round.
               retry_d = retry_q + 1'b1;
               ptr_d   = sel_q;
            end else begin
               drop_d[sel_q] = 1'b1;
               if (drop_count != '1) dcnt_d = drop_count + 16'd1;
               ptr_d   = sel_inc;
               retry_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         sel_q        <= '0;
         retry_q      <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
         gnt          <= '0;
         drop         <= '0;
         drop_count   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         sel_q        <= sel_d;
         retry_q      <= retry_d;
         fifo_wr_en   <= wr_en_d;
         fifo_data_in <= data_d;
         gnt          <= gnt_d;
         drop         <= drop_d;
         drop_count   <= dcnt_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO (16-bit wide, 8 deep) among NUM_REQ requesters.
- Samples requests and issues one registered write at a time to the FIFO.
- Confirms each write against the FIFO's wr_ack and retries writes rejected on overflow.
- Sits between producer blocks and the FIFO DUT modport inputs wr_en/data_in.

Parameters:
- FIFO_WIDTH, 16, data width of each requester and of the FIFO write data.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 3, overflow-rejected attempts allowed per request before it is dropped.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request, level, held until gnt or drop.
- req_data  input  NUM_REQ*FIFO_WIDTH  requester i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH], stable while req[i]=1.
- gnt  output  NUM_REQ  one-cycle one-hot pulse: requester's word was written (wr_ack seen).
- drop  output  NUM_REQ  one-cycle one-hot pulse: request abandoned after MAX_RETRY rejections.
- fifo_wr_en  output  1  FIFO write enable, registered.
- fifo_data_in  output  FIFO_WIDTH  FIFO write data, registered.
- fifo_wr_ack  input  1  FIFO write acknowledge, valid the cycle after fifo_wr_en.
- fifo_full  input  1  FIFO full flag.
- fifo_almostfull  input  1  FIFO almost-full flag.
- busy  output  1  high when not in IDLE.
- drop_count  output  16  saturating count of dropped requests.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, drop=0, fifo_wr_en=0, fifo_data_in=0, busy=0, drop_count=0.
  - Round-robin pointer ptr=0, retry counter=0, state=IDLE.
  - Reset asserted mid-transaction aborts the transaction immediately; no gnt or drop is emitted for it.
- State machine: IDLE -> ISSUE -> ACK -> IDLE.
- IDLE:
  - Stays in IDLE if req==0 or fifo_full=1.
  - Otherwise selects the first requester with req=1, searching from index ptr upward with wrap-around at NUM_REQ-1 -> 0, and latches its index as sel.
  - Next edge: fifo_wr_en=1, fifo_data_in=req_data[sel], state=ISSUE.
- ISSUE: lasts exactly one cycle with fifo_wr_en=1. Next edge: fifo_wr_en=0, state=ACK.
- ACK (samples fifo_wr_ack):
  - fifo_wr_ack=1: gnt[sel] pulses at the next edge; ptr=(sel+1) mod NUM_REQ; retry=0; state=IDLE.
  - fifo_wr_ack=0, retry<MAX_RETRY-1: retry+1; ptr=sel so the same requester keeps priority; state=IDLE.
  - fifo_wr_ack=0, retry=MAX_RETRY-1: drop[sel] pulses; drop_count+1, saturating at 16'hFFFF; ptr=(sel+1) mod NUM_REQ; retry=0; state=IDLE.
- Throughput: at most one write per 3 cycles.
  - Latency from req rise (IDLE, FIFO not full) to gnt pulse is 3 cycles.
- fifo_almostfull=1 gates nothing. It is ignored because only one write is ever in flight.
- gnt and drop are never asserted together and are never asserted outside the ACK->IDLE edge.
- A requester that deasserts req while selected is a protocol violation. The arbiter still completes the write with the latched data.
- busy = (state != IDLE).

Test Plan:
- Reset then req=4'b0001, req_data[0]=16'hA5A5, FIFO empty -> fifo_wr_en high one cycle with data 16'hA5A5; gnt=4'b0001 three cycles after req; ptr=1.
- req=4'b1111 held, FIFO draining -> gnt order 0,1,2,3,0 with one gnt every 3 cycles; no drop.
- FIFO filled to 8 entries, req=4'b0100, no reads -> bench stays in IDLE (fifo_full=1); no fifo_wr_en; busy=0; read one word -> write issued; gnt=4'b0100.
- Force fifo_wr_ack=0 on every attempt for requester 2, MAX_RETRY=3 -> three fifo_wr_en pulses, then drop=4'b0100; drop_count=1; next grant goes to requester 3.
- First attempt from requester 1 rejected, second acked, req=4'b0011 -> requester 1 retried before requester 0 is served; gnt=4'b0010, then gnt=4'b0001.
- rst_n pulsed low during ISSUE -> fifo_wr_en drops to 0 asynchronously; no gnt; after release, ptr=0 and arbitration restarts from requester 0.
